// File: rtl/env_pkg.sv
// Shared constants for the envelope detector: default widths, boxcar depth and pipeline latencies.
package env_pkg;
  localparam int ENV_IN_WIDTH   = 24;
  localparam int ENV_DATA_WIDTH = 48;
  localparam int ENV_AVG_LOG2   = 2;
  localparam int ENV_LAT_RAW    = 3;
  localparam int ENV_LAT_SMOOTH = 4;
endpackage

// File: rtl/env_boxcar.sv
// Per-scan-line boxcar average of the power stream: circular history, write pointer and running sum.
// A valid sample flagged as line start restarts the history with that sample alone.
module env_boxcar import env_pkg::*; #(
  parameter int DATA_WIDTH = ENV_DATA_WIDTH,
  parameter int AVG_LOG2   = ENV_AVG_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic                  i_line_start,
  input  logic [DATA_WIDTH-1:0] i_power,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_avg
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_WIDTH + AVG_LOG2;

  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [AVG_LOG2-1:0]   r_wptr;
  logic [SUM_W-1:0]      r_sum;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_avg;

  logic [SUM_W-1:0]      w_sum_base;
  logic [SUM_W-1:0]      w_old_ext;
  logic [SUM_W-1:0]      w_p_ext;
  logic [SUM_W-1:0]      w_sum_next;

  // On a line start the old history counts as zero, so the new sum is just this sample.
  always_comb begin
    w_sum_base = '0;
    w_old_ext  = '0;
    w_p_ext    = {{AVG_LOG2{1'b0}}, i_power};
    if (!i_line_start) begin
      w_sum_base = r_sum;
      w_old_ext  = {{AVG_LOG2{1'b0}}, r_buf[r_wptr]};
    end
    w_sum_next = w_sum_base + w_p_ext - w_old_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
      r_wptr  <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
      r_avg   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sum <= w_sum_next;
        r_avg <= w_sum_next[SUM_W-1:AVG_LOG2];
        if (i_line_start) begin
          for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
          r_buf[0] <= i_power;
          r_wptr   <= AVG_LOG2'(1);
        end else begin
          r_buf[r_wptr] <= i_power;
          r_wptr        <= r_wptr + AVG_LOG2'(1);
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_avg   = r_avg;
endmodule

// File: rtl/env_detect.sv
// Streaming envelope detector: registers I/Q, squares, sums to 48-bit power, optionally boxcar-smooths.
// Build option ENV_SMOOTH_EN adds the env_boxcar stage (latency 4); otherwise raw power (latency 3).
module env_detect import env_pkg::*; #(
  parameter int IN_WIDTH   = ENV_IN_WIDTH,
  parameter int DATA_WIDTH = ENV_DATA_WIDTH,
  parameter int AVG_LOG2   = ENV_AVG_LOG2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       line_start,
  input  logic signed [IN_WIDTH-1:0] i_in,
  input  logic signed [IN_WIDTH-1:0] q_in,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      env_out
);
  logic signed [IN_WIDTH-1:0]   r_i1, r_q1;
  logic                         r_v1, r_ls1;
  logic [DATA_WIDTH-1:0]        r_ii2, r_qq2;
  logic                         r_v2, r_ls2;
  logic [DATA_WIDTH-1:0]        r_p3;
  logic                         r_v3, r_ls3;
  logic                         r_out_valid;
  logic [DATA_WIDTH-1:0]        r_env;

  logic signed [DATA_WIDTH-1:0] w_i_ext, w_q_ext;
  logic signed [DATA_WIDTH-1:0] w_ii, w_qq;
  logic                         w_fin_valid;
  logic [DATA_WIDTH-1:0]        w_fin_data;

  // Squares of a two's complement value are non-negative and fit in 2*IN_WIDTH bits.
  assign w_i_ext = {{(DATA_WIDTH-IN_WIDTH){r_i1[IN_WIDTH-1]}}, r_i1};
  assign w_q_ext = {{(DATA_WIDTH-IN_WIDTH){r_q1[IN_WIDTH-1]}}, r_q1};
  assign w_ii    = w_i_ext * w_i_ext;
  assign w_qq    = w_q_ext * w_q_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i1  <= '0;
      r_q1  <= '0;
      r_v1  <= 1'b0;
      r_ls1 <= 1'b0;
      r_ii2 <= '0;
      r_qq2 <= '0;
      r_v2  <= 1'b0;
      r_ls2 <= 1'b0;
      r_p3  <= '0;
      r_v3  <= 1'b0;
      r_ls3 <= 1'b0;
    end else begin
      r_v1  <= in_valid;
      r_ls1 <= in_valid & line_start;
      if (in_valid) begin
        r_i1 <= i_in;
        r_q1 <= q_in;
      end
      r_v2  <= r_v1;
      r_ls2 <= r_ls1;
      if (r_v1) begin
        r_ii2 <= w_ii;
        r_qq2 <= w_qq;
      end
      r_v3  <= r_v2;
      r_ls3 <= r_ls2;
      // Peak is 2^47 when both inputs are the most negative value, so no carry is lost.
      if (r_v2) r_p3 <= r_ii2 + r_qq2;
    end
  end

`ifdef ENV_SMOOTH_EN
  env_boxcar #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_LOG2   (AVG_LOG2)
  ) u_boxcar (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (r_v3),
    .i_line_start (r_ls3),
    .i_power      (r_p3),
    .o_valid      (w_fin_valid),
    .o_avg        (w_fin_data)
  );
`else
  logic w_unused_raw;
  assign w_fin_valid  = r_v3;
  assign w_fin_data   = r_p3;
  assign w_unused_raw = ^{r_ls3, (AVG_LOG2 != 0)};
`endif

  // Output register holds the last result through bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_env       <= '0;
    end else begin
      r_out_valid <= w_fin_valid;
      if (w_fin_valid) r_env <= w_fin_data;
    end
  end

  assign out_valid = r_out_valid;
  assign env_out   = r_env;
endmodule

// File: tb/tb_env_detect.sv
// Self-checking bench for env_detect: directed steps then random traffic against a line-history power model.
module tb_env_detect;
  import env_pkg::*;

  localparam int IW    = ENV_IN_WIDTH;
  localparam int DW    = ENV_DATA_WIDTH;
  localparam int AL    = ENV_AVG_LOG2;
  localparam int DEPTH = 1 << AL;
`ifdef ENV_SMOOTH_EN
  localparam int LAT    = ENV_LAT_SMOOTH;
  localparam bit SMOOTH = 1'b1;
`else
  localparam int LAT    = ENV_LAT_RAW;
  localparam bit SMOOTH = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 line_start;
  logic signed [IW-1:0] i_in;
  logic signed [IW-1:0] q_in;
  logic                 out_valid;
  logic [DW-1:0]        env_out;

  always #5 clk = ~clk;

  env_detect #(
    .IN_WIDTH   (IW),
    .DATA_WIDTH (DW),
    .AVG_LOG2   (AL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .line_start (line_start),
    .i_in       (i_in),
    .q_in       (q_in),
    .out_valid  (out_valid),
    .env_out    (env_out)
  );

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          exp_q[$];
  longint        hist[$];
  logic [DW-1:0] exp_env;
  bit            exp_v;
  int            n_cmp;
  int            n_err;

  // Power is I^2+Q^2; smoothed value is the sum of the last DEPTH powers of the current line / DEPTH.
  function automatic logic [DW-1:0] model(input bit ls, input longint i, input longint q);
    longint p;
    longint s;
    p = i * i + q * q;
    if (!SMOOTH) return DW'(p);
    if (ls) hist.delete();
    hist.push_back(p);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    s = 0;
    foreach (hist[k]) s += hist[k];
    return DW'(s >> AL);
  endfunction

  task automatic flush();
    ent_t e;
    e.v = 1'b0;
    e.d = '0;
    exp_q.delete();
    repeat (LAT) exp_q.push_back(e);
    hist.delete();
    exp_env = '0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit ls,
                      input logic signed [IW-1:0] i, input logic signed [IW-1:0] q);
    ent_t e;
    ent_t f;
    @(negedge clk);
    reset      = rst;
    in_valid   = v;
    line_start = ls;
    i_in       = i;
    q_in       = q;
    @(posedge clk);
    #1;
    if (rst) begin
      flush();
      exp_v = 1'b0;
    end else begin
      e.v = v;
      e.d = v ? model(ls, longint'(i), longint'(q)) : '0;
      exp_q.push_back(e);
      f = exp_q.pop_front();
      exp_v = f.v;
      if (f.v) exp_env = f.d;
    end
    check("out_valid", DW'(out_valid), DW'(exp_v));
    check("env_out", env_out, exp_env);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  logic signed [IW-1:0] r_i;
  logic signed [IW-1:0] r_q;
  logic signed [IW-1:0] most_neg;
  logic signed [IW-1:0] most_pos;
  bit                   r_v;
  bit                   r_ls;
  bit                   r_rst;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    line_start = 1'b0;
    i_in       = '0;
    q_in       = '0;
    exp_v      = 1'b0;
    most_neg   = {1'b1, {(IW-1){1'b0}}};
    most_pos   = {1'b0, {(IW-1){1'b1}}};
    flush();

    // Reset state, with in_valid asserted during reset to show reset wins.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 24'sd5, 24'sd5);
    step(1'b1, 1'b0, 1'b0, '0, '0);

    // Single pulse I=3, Q=4, then hold.
    step(1'b0, 1'b1, 1'b1, 24'sd3, 24'sd4);
    idle(LAT + 3);
    check("pulse_lit", env_out, SMOOTH ? 48'd6 : 48'd25);

    // Extremes.
    step(1'b0, 1'b1, 1'b1, most_neg, most_neg);
    idle(LAT + 1);
    check("ext_neg_lit", env_out, SMOOTH ? 48'h200000000000 : 48'h800000000000);
    step(1'b0, 1'b1, 1'b1, most_pos, '0);
    idle(LAT + 1);
    check("ext_pos_lit", env_out, SMOOTH ? 48'h0FFFFFC00000 : 48'h3FFFFF000001);

    // Constant P=16 line, then mid-line restart with P=100.
    step(1'b0, 1'b1, 1'b1, 24'sd4, 24'sd0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 24'sd4, 24'sd0);
    step(1'b0, 1'b1, 1'b1, 24'sd10, 24'sd0);
    idle(LAT + 1);
    check("restart_lit", env_out, SMOOTH ? 48'd25 : 48'd100);

    // Bubbles every other cycle, with garbage on the data inputs in the gaps.
    step(1'b0, 1'b1, 1'b1, 24'sd4, 24'sd0);
    repeat (5) begin
      step(1'b0, 1'b0, 1'b1, 24'sd77, -24'sd9);
      step(1'b0, 1'b1, 1'b0, 24'sd4, 24'sd0);
    end
    idle(LAT + 1);

    // Reset mid-stream with three samples in flight; next sample sees empty history.
    step(1'b0, 1'b1, 1'b1, 24'sd100, 24'sd0);
    step(1'b0, 1'b1, 1'b0, 24'sd200, 24'sd0);
    step(1'b0, 1'b1, 1'b0, 24'sd300, 24'sd0);
    step(1'b1, 1'b1, 1'b0, 24'sd400, 24'sd0);
    step(1'b0, 1'b1, 1'b0, 24'sd4, 24'sd0);
    idle(LAT + 1);
    check("post_reset_lit", env_out, SMOOTH ? 48'd4 : 48'd16);

    // Random traffic.
    repeat (400) begin
      r_v   = ($urandom_range(0, 9) < 7);
      r_ls  = ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      r_i   = IW'($urandom);
      r_q   = IW'($urandom);
      if ($urandom_range(0, 15) == 0) r_i = most_neg;
      if ($urandom_range(0, 15) == 0) r_q = most_neg;
      step(r_rst, r_v, r_ls, r_i, r_q);
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/env_detect.md
# env_detect

Envelope detector feeding the log-compression stage of the ultrasound receive chain. It takes beamformed baseband I/Q sample pairs and computes instantaneous power I²+Q² as a 48-bit unsigned word, which is the log compressor's native input width. It optionally smooths the power with a per-scan-line boxcar average to reduce speckle before compression. It is a fully pipelined streaming stage: one sample per clock, valid-qualified, with no backpressure.

## Interface
- IN_WIDTH, 24: signed width of each I and Q input sample.
- DATA_WIDTH, 48: width of the unsigned power output. Must equal 2*IN_WIDTH.
- AVG_LOG2, 2: log2 of the boxcar depth. Depth is 2^AVG_LOG2; the legal range is 1..4. Used only when smoothing is compiled in.
- clk, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: i_in, q_in and line_start are valid this cycle.
- line_start, input, 1: the qualified sample is the first sample of a new scan line.
- i_in, input, IN_WIDTH: in-phase sample, two's complement.
- q_in, input, IN_WIDTH: quadrature sample, two's complement.
- out_valid, input-aligned, output, 1: env_out carries a new result.
- env_out, output, DATA_WIDTH: power, or averaged power when smoothing is enabled. Unsigned.

## Operation
- Stage 1 registers i_in, q_in, in_valid and line_start.
- Stage 2 computes the signed products I*I and Q*Q and registers them. Each product is 2*IN_WIDTH bits and non-negative.
- Stage 3 computes the unsigned sum P = I² + Q² at DATA_WIDTH bits.
  - The largest value is 2^47, reached when both inputs are -2^23. It fits in 48 bits, so no saturation is needed.
- The valid and line_start flags travel in shift-register lockstep with the data.
- When in_valid is low, a bubble travels down the pipe:
  - out_valid is deasserted for that slot.
  - env_out holds its previous value.
  - The boxcar history does not advance.
- Smoothing (Stage 4, only when compiled in):
  - The block keeps a circular buffer of the last 2^AVG_LOG2 powers, a write pointer, and a running sum SUM of width DATA_WIDTH+AVG_LOG2.
  - On each valid P: SUM_next = SUM + P - buf[wptr]; then buf[wptr] = P; wptr increments and wraps modulo the depth.
  - env_out = SUM_next >> AVG_LOG2, truncated with no rounding.
  - On a valid P whose aligned line_start is 1, the history is cleared in the same cycle: the buffer entries and SUM are treated as zero. So SUM_next = P, buf[0] = P and wptr = 1.
  - Warm-up is not compensated. The first depth-1 outputs of a line are scaled down because zero history is included in the sum.
  - line_start with in_valid low is ignored.
- Reset clears all pipeline registers, the valid flags, the buffer, SUM and wptr. Samples in flight when reset is asserted are discarded. No stale out_valid appears after reset is released.

## Timing
- Reset values: out_valid = 0 and env_out = 0. All internal state is 0.
- Throughput: one sample per clock, continuously.
- Raw-power latency: a sample accepted on edge n produces out_valid=1 with its result after edge n+3.
- Smoothed latency: one additional cycle, so the result appears after edge n+4.
- out_valid is high for exactly one cycle per accepted sample. Output order matches input order.
- Reset asserted on any edge takes priority over in_valid sampled on that same edge.

## Configuration
- ENV_SMOOTH_EN defined:
  - Stage 4 and the boxcar buffer are instantiated.
  - Latency is 4 cycles.
  - line_start is functional.
- ENV_SMOOTH_EN undefined:
  - env_out is the raw Stage 3 power.
  - Latency is 3 cycles.
  - line_start is accepted but unused.
  - AVG_LOG2 has no effect.

## Structure
- The shared package env_pkg holds:
  - the default IN_WIDTH, DATA_WIDTH and AVG_LOG2 constants;
  - the pipeline latency constants ENV_LAT_RAW=3 and ENV_LAT_SMOOTH=4.
- The top-level module owns Stages 1–3 and the flag shift register.
- The boxcar is one sub-module, env_boxcar (circular buffer, pointer, running sum, line clear). It is instantiated only under ENV_SMOOTH_EN.

## Test plan
- Raw mode: I=3, Q=4 with a single in_valid pulse -> out_valid pulses once, 3 cycles later, with env_out=25. env_out then holds 25.
- Extremes, raw mode:
  - I=Q=-8388608 -> env_out=0x800000000000.
  - I=8388607, Q=0 -> env_out=0x3FFFFF000001.
- Smoothed mode, AVG_LOG2=2: line_start on the first sample, then a constant P=16 (I=4, Q=0) for 6 samples -> outputs 4, 8, 12, 16, 16, 16, with latency 4.
- Smoothed mode: line_start reasserted mid-stream while history holds 16s, with the new sample P=100 -> output 25. Earlier history is excluded.
- Bubbles: valid samples P=16 with in_valid low every other cycle -> out_valid toggles. The smoothed sequence equals the gap-free sequence, and env_out holds during the gaps.
- Reset mid-stream: reset pulsed for 1 cycle with 3 samples in flight -> none of those samples appear at the output. The next accepted sample after release behaves as after power-up, with history zero.
